// File: rtl/nios2_debug_host_shifter.sv
// In-fabric JTAG host for the Nios II debug slave: runs one UIR/CDR/SDR/UDR/RTI
// sequence on a divided virtual tck per command and returns the captured DR word.
module nios2_debug_host_shifter #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int DIV_W   = $clog2(TCK_HALF) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIV_W-1:0]    r_div;
  logic                r_tck;
  logic [CNT_W-1:0]    r_cnt;
  logic [DR_WIDTH-1:0] r_sr;
  logic                r_tdi;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic [IR_WIDTH-1:0] r_ir_out;
  logic [4:0]          r_strb;
  logic                r_busy;
  logic                r_ready;
  logic                r_rsp_valid;

  logic w_active;
  logic w_wrap;
  logic w_rise;
  logic w_fall;
  logic w_last_bit;
  logic w_last_rti;

  // Strobe vector order: {uir, cdr, sdr, udr, rti}
  function automatic logic [4:0] f_strobes(input state_t s);
    case (s)
      S_UIR:   f_strobes = 5'b10000;
      S_CDR:   f_strobes = 5'b01000;
      S_SHIFT: f_strobes = 5'b00100;
      S_UDR:   f_strobes = 5'b00010;
      S_RTI:   f_strobes = 5'b00001;
      default: f_strobes = 5'b00000;
    endcase
  endfunction

  assign w_active   = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_wrap     = (r_div == DIV_W'(TCK_HALF - 1));
  assign w_rise     = w_active && w_wrap && !r_tck;
  // Falling tck edge closes the current phase
  assign w_fall     = w_active && w_wrap && r_tck;
  assign w_last_bit = (r_cnt == CNT_W'(DR_WIDTH - 1));
  assign w_last_rti = (r_cnt == CNT_W'(RTI_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = cmd_skip_ir ? S_CDR : S_UIR;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      S_UIR:   if (w_fall) w_next = S_CDR;
      S_CDR:   if (w_fall) w_next = S_SHIFT;
      S_SHIFT: if (w_fall && w_last_bit) w_next = S_UDR;
      S_UDR:   if (w_fall) w_next = S_RTI;
      S_RTI:   if (w_fall && w_last_rti) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_tck       <= 1'b0;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_tdi       <= 1'b0;
      r_ir_in     <= '0;
      r_ir_out    <= '0;
      r_strb      <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_strb  <= f_strobes(w_next);
      r_busy  <= (w_next != S_IDLE) && (w_next != S_RESP);
      r_ready <= (w_next == S_IDLE);

      if (r_state == S_IDLE && cmd_valid) begin
        r_sr  <= cmd_data;
        r_div <= '0;
        r_tck <= 1'b0;
        if (!cmd_skip_ir) r_ir_in <= cmd_ir;
      end

      if (r_state == S_RESP && rsp_ready) r_rsp_valid <= 1'b0;

      if (w_active) begin
        if (w_wrap) begin
          r_div <= '0;
          r_tck <= ~r_tck;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      if (w_rise && r_state == S_CDR)   r_ir_out <= vji_ir_out;
      if (w_rise && r_state == S_SHIFT) r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};

      // tdi only changes at phase boundaries so it is stable across the period
      if (w_fall) begin
        case (r_state)
          S_CDR: begin
            r_cnt <= '0;
            r_tdi <= r_sr[0];
          end
          S_SHIFT: begin
            if (w_last_bit) begin
              r_cnt <= '0;
              r_tdi <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_tdi <= r_sr[0];
            end
          end
          S_UDR: r_cnt <= '0;
          S_RTI: begin
            if (w_last_rti) r_rsp_valid <= 1'b1;
            else            r_cnt <= r_cnt + CNT_W'(1);
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign cmd_ready  = r_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_sr;
  assign rsp_ir_out = r_ir_out;
  assign busy       = r_busy;
  assign vji_tck    = r_tck;
  assign vji_tdi    = r_tdi;
  assign vji_ir_in  = r_ir_in;
  assign vji_uir    = r_strb[4];
  assign vji_cdr    = r_strb[3];
  assign vji_sdr    = r_strb[2];
  assign vji_udr    = r_strb[1];
  assign vji_rti    = r_strb[0];

endmodule

// File: tb/tb_nios2_debug_host_shifter.sv
// Scoreboard bench for nios2_debug_host_shifter with a behavioural virtual-JTAG slave.
module tb_nios2_debug_host_shifter;

  localparam int DW = 38;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_ir;
  logic          cmd_skip_ir;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rsp_ir_out;
  logic          busy;
  logic          vji_tck;
  logic          vji_tdi;
  logic          vji_tdo;
  logic [IW-1:0] vji_ir_in;
  logic [IW-1:0] vji_ir_out;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  always #5 clk = ~clk;

  nios2_debug_host_shifter dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_skip_ir(cmd_skip_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out), .busy(busy),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  // Behavioural slave: captures on cdr, shifts on sdr, reports what it received at udr
  logic          tdo_tie;
  logic [IW-1:0] slave_ir_out;
  logic [DW-1:0] slave_load;
  logic [DW-1:0] slave_sr = '0;
  logic [DW-1:0] slave_rx = '0;

  assign vji_tdo    = tdo_tie ? 1'b1 : slave_sr[0];
  assign vji_ir_out = slave_ir_out;

  always @(posedge vji_tck) begin
    if (vji_cdr)      slave_sr <= slave_load;
    else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[DW-1:1]};
    if (vji_udr)      slave_rx <= slave_sr;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sdr_edges = 0;
  int tdi_ones = 0;
  int uir_cycles = 0;
  int rsp_rises = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] ir;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge vji_tck) if (vji_sdr) sdr_edges++;

  always @(negedge clk) begin
    if (vji_sdr && vji_tdi) tdi_ones++;
    if (vji_uir) uir_cycles++;
  end

  // Monitor: compare each response as rsp_valid rises
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1 && prev_valid === 1'b0) begin
      rsp_rises++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.d));
        chk("rsp_ir_out", 64'(rsp_ir_out), 64'(e.ir));
        chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] d, input logic skip,
                       input bit push, input logic [DW-1:0] ed, input logic [IW-1:0] eir,
                       input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) chk("issue_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_ir      = ir;
    cmd_data    = d;
    cmd_skip_ir = skip;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (push) sb.push_back('{ed, eir, lat, cyc});
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_sdr, s_tdi, s_uir, s_rise, bad, n;
    logic [DW-1:0] hd;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_skip_ir = 1'b0; cmd_data = '0;
    rsp_ready = 1'b1; tdo_tie = 1'b1; slave_ir_out = 2'b00; slave_load = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_tck", 64'(vji_tck), 64'd0);
    chk("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
    chk("rst_ir_in", 64'(vji_ir_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);

    // tdo tied high: all-ones capture, tdi stays 0 since the data word is 0
    s_sdr = sdr_edges; s_tdi = tdi_ones;
    issue(2'b01, 38'h0, 1'b0, 1'b1, 38'h3F_FFFF_FFFF, 2'b00, 168);
    chk("uir_entry", 64'(vji_uir), 64'd1);
    chk("ir_in_uir", 64'(vji_ir_in), 64'd1);
    wait_rsp();
    chk("sdr_edges", 64'(sdr_edges - s_sdr), 64'd38);
    chk("tdi_zero", 64'(tdi_ones - s_tdi), 64'd0);
    repeat (3) @(negedge clk);

    // Slave model exchange
    tdo_tie = 1'b0; slave_ir_out = 2'b10; slave_load = 38'h2A_5A5A_A5A5;
    issue(2'b11, 38'h15_A5A5_5A5A, 1'b0, 1'b1, 38'h2A_5A5A_A5A5, 2'b10, 168);
    wait_rsp();
    chk("slave_rx", 64'(slave_rx), 64'(38'h15_A5A5_5A5A));
    repeat (3) @(negedge clk);

    // Skip IR: no uir pulse, ir_in keeps 2'b11, one period shorter
    s_uir = uir_cycles;
    issue(2'b00, 38'h12_3456_789A, 1'b1, 1'b1, 38'h2A_5A5A_A5A5, 2'b10, 164);
    chk("skip_cdr_entry", 64'(vji_cdr), 64'd1);
    wait_rsp();
    chk("skip_no_uir", 64'(uir_cycles - s_uir), 64'd0);
    chk("skip_ir_in", 64'(vji_ir_in), 64'd3);
    chk("skip_slave_rx", 64'(slave_rx), 64'(38'h12_3456_789A));
    repeat (3) @(negedge clk);

    // Backpressure on the response
    rsp_ready = 1'b0;
    issue(2'b11, 38'h0F_0F0F_0F0F, 1'b0, 1'b1, 38'h2A_5A5A_A5A5, 2'b10, 168);
    wait_rsp();
    hd = rsp_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cmd_valid = (i % 2 == 0);
      cmd_data  = 38'h3F_0000_1111;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || cmd_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_data", 64'(hd), 64'(38'h2A_5A5A_A5A5));
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);
    chk("ignored_cmd_busy", 64'(busy), 64'd0);

    // Reset during SHIFT aborts with no response
    s_sdr = sdr_edges; s_rise = rsp_rises;
    issue(2'b01, 38'h3F_FFFF_0000, 1'b0, 1'b0, '0, '0, 0);
    n = 0;
    while ((sdr_edges - s_sdr) < 17 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit17", 64'(sdr_edges - s_sdr), 64'd17);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_tck", 64'(vji_tck), 64'd0);
    chk("abort_sdr", 64'(vji_sdr), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (300) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_rises - s_rise), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_debug_host_shifter.md
Name: nios2_debug_host_shifter

Overview:
- In-fabric JTAG host for the Nios II debug slave. It drives the slave's virtual-JTAG signals (tck, tdi, ir_in and the uir/cdr/sdr/udr/rti state strobes) and captures tdo and ir_out.
- Takes one command: IR value plus a DR word to shift. Runs a complete UIR->CDR->SDR->UDR->RTI sequence on a divided tck. Returns the captured DR word.
- Used by on-chip test and boot controllers to reach debug registers without an external JTAG cable.

Parameters:
- DR_WIDTH, 38, DR shift length in bits; must match the slave's sr width.
- IR_WIDTH, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half-period; minimum 1.
- RTI_CYCLES, 1, tck periods spent in RTI after UDR; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  host idle, command accepted when valid&ready.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_skip_ir  in  1  1 = omit UIR phase and keep the current ir_in.
- cmd_data  in  DR_WIDTH  DR word shifted out LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  captured tdo word, first-captured bit at [0].
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during CDR.
- busy  out  1  sequence in progress (state not IDLE/RESP).
- vji_tck  out  1  virtual tck.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  virtual IR.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset values: all vji_* outputs 0; rsp_valid=0; rsp_data=0; rsp_ir_out=0; busy=0; cmd_ready=1; state=IDLE. Reset mid-sequence aborts immediately: tck forced low, all strobes dropped, no response produced.
- tck generator:
  - A half-period counter counts 0..TCK_HALF-1. When it wraps, tck toggles.
  - tck idles low in IDLE and RESP.
  - Each phase begins with tck low and lasts exactly one tck period (2*TCK_HALF clk cycles), low half first.
- FSM states: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP.
  - IDLE: cmd_ready=1. On accept, latch cmd_data into the shift register. Go to UIR, or to CDR if cmd_skip_ir=1.
  - UIR (1 tck period): vji_uir=1. vji_ir_in<=cmd_ir on entry; it holds until the next UIR.
  - CDR (1 period): vji_cdr=1. vji_ir_out is sampled into rsp_ir_out on the tck rising edge.
  - SHIFT (DR_WIDTH periods):
    - vji_sdr=1; vji_tdi=sr[0], stable for the whole period.
    - On each tck rising edge, sample: sr<={vji_tdo, sr[DR_WIDTH-1:1]}.
    - A bit counter 0..DR_WIDTH-1 exits after the last rising edge completes its high half.
  - UDR (1 period): vji_udr=1.
  - RTI (RTI_CYCLES periods): vji_rti=1.
  - RESP: rsp_valid=1 with rsp_data=sr. Both are held stable until rsp_ready=1. Then go to IDLE with rsp_valid<=0.
- Exactly one strobe is high in any non-idle phase. Strobes change only on clk edges where tck goes low (phase boundaries).
- vji_tdi=0 outside SHIFT.
- cmd_ready=0 from accept through the rsp handshake cycle. A new command is accepted at the earliest on the cycle after the rsp_valid&rsp_ready cycle.
- cmd_valid asserted while not ready is ignored; inputs are not latched.
- Latency: rsp_valid rises 2*TCK_HALF*(3+DR_WIDTH+RTI_CYCLES) clk cycles after the accept edge. With cmd_skip_ir=1 it is one period less. Defaults give 168 and 164 cycles.
- rsp_ready high when rsp_valid rises completes the handshake in that same cycle (rsp_valid high for one cycle).
- busy=1 in UIR..RTI.

Test Plan:
- Reset, then idle 20 cycles -> cmd_ready=1, rsp_valid=0, vji_tck=0, all strobes 0, vji_ir_in=2'b00.
- vji_tdo tied 1; cmd_ir=2'b01, cmd_data=38'h0, skip=0 -> rsp_valid at cycle 168 after accept; rsp_data=38'h3F_FFFF_FFFF. vji_ir_in=2'b01 from UIR entry. Exactly 38 tck rising edges with vji_sdr=1, vji_tdi=0 throughout.
- Behavioural slave model returning 38'h2A_5A5A_A5A5 LSB first, with vji_ir_out=2'b10; cmd_data=38'h15_A5A5_5A5A -> rsp_data=38'h2A_5A5A_A5A5, rsp_ir_out=2'b10. The model receives 38'h15_A5A5_5A5A at udr.
- skip_ir=1 after a prior cmd_ir=2'b11 -> no vji_uir pulse; vji_ir_in stays 2'b11; rsp_valid at cycle 164.
- Hold rsp_ready=0 for 50 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, and cmd_valid pulses are ignored. Then rsp_ready=1 for one cycle -> rsp_valid=0 and cmd_ready=1 on the next cycle.
- Assert reset during SHIFT at bit 17 -> next cycle vji_tck=0, vji_sdr=0, busy=0, cmd_ready=1; no rsp_valid ever produced for the aborted command.
